// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store initiator: funct3 codes, word size,
// FSM states and request-decoding helpers.
package mem_access_unit_pkg;

  localparam int unsigned WORDSIZE = 32;

  localparam logic [2:0] FUNCT_LB  = 3'b000;
  localparam logic [2:0] FUNCT_LH  = 3'b001;
  localparam logic [2:0] FUNCT_LW  = 3'b010;
  localparam logic [2:0] FUNCT_LBU = 3'b100;
  localparam logic [2:0] FUNCT_LHU = 3'b101;
  localparam logic [2:0] FUNCT_SB  = 3'b000;
  localparam logic [2:0] FUNCT_SH  = 3'b001;
  localparam logic [2:0] FUNCT_SW  = 3'b010;

  typedef enum logic [1:0] {
    MAU_IDLE   = 2'd0,
    MAU_ACCESS = 2'd1,
    MAU_RESP   = 2'd2
  } mau_state_t;

  function automatic logic f3_illegal(input logic write, input logic [2:0] funct3);
    if (write)
      return !(funct3 == FUNCT_SB || funct3 == FUNCT_SH || funct3 == FUNCT_SW);
    else
      return (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
  endfunction

  // Index of the final byte (N-1); funct3[1:0] selects byte/half/word.
  function automatic logic [1:0] last_idx(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of the assembled load shift register by funct3.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic [WORDSIZE-1:0] shreg,
  output logic [WORDSIZE-1:0] ext
);

  always_comb begin
    ext = '0;
    case (funct3)
      FUNCT_LB:  ext = {{24{shreg[7]}}, shreg[7:0]};
      FUNCT_LBU: ext = {24'd0, shreg[7:0]};
      FUNCT_LH:  ext = {{16{shreg[15]}}, shreg[15:0]};
      FUNCT_LHU: ext = {16'd0, shreg[15:0]};
      FUNCT_LW:  ext = shreg;
      default:   ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle byte-serial load/store initiator, MSB at lowest address,
// with misalignment / illegal-funct3 detection and a one-cycle response.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [WORDSIZE-1:0] req_addr,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic                resp_err,
  output logic [WORDSIZE-1:0] mem_addr,
  output logic                mem_we,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata
);

  mau_state_t r_state, r_next;

  logic                r_write;
  logic [2:0]          r_funct3;
  logic [WORDSIZE-1:0] r_addr;
  logic [WORDSIZE-1:0] r_wdata;
  logic [1:0]          r_last;
  logic [1:0]          r_cnt;
  logic [WORDSIZE-1:0] r_shreg;
  logic                r_err;

  logic                w_misalign;
  logic                w_err;
  logic [1:0]          w_byte_sel;
  logic [WORDSIZE-1:0] w_ext;

  assign w_misalign = CHECK_ALIGN &&
                      (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
  assign w_err      = f3_illegal(req_write, req_funct3) || w_misalign;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_state <= MAU_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      MAU_IDLE:   if (req_valid) r_next = w_err ? MAU_RESP : MAU_ACCESS;
      MAU_ACCESS: if (r_cnt == r_last) r_next = MAU_RESP;
      MAU_RESP:   r_next = MAU_IDLE;
      default:    r_next = MAU_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_write  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_last   <= '0;
      r_cnt    <= '0;
      r_shreg  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        MAU_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_last   <= last_idx(req_funct3);
            r_err    <= w_err;
            r_cnt    <= '0;
            r_shreg  <= '0;
          end
        end
        MAU_ACCESS: begin
          r_cnt <= r_cnt + 2'd1;
          if (!r_write) r_shreg <= {r_shreg[23:0], mem_rdata};
        end
        default: ;
      endcase
    end
  end

  load_extend u_load_extend (
    .funct3 (r_funct3),
    .shreg  (r_shreg),
    .ext    (w_ext)
  );

  // Store bytes go out MSB-first: byte k comes from lane (N-1-k) of wdata.
  assign w_byte_sel = r_last - r_cnt;

  assign req_ready  = (r_state == MAU_IDLE);
  assign resp_valid = (r_state == MAU_RESP);
  assign resp_err   = (r_state == MAU_RESP) && r_err;
  assign resp_rdata = ((r_state == MAU_RESP) && !r_write && !r_err) ? w_ext : '0;
  assign mem_we     = (r_state == MAU_ACCESS) && r_write;
  assign mem_addr   = (r_state == MAU_ACCESS) ? (r_addr + {30'd0, r_cnt}) : '0;
  assign mem_wdata  = mem_we ? r_wdata[{w_byte_sel, 3'b000} +: 8] : '0;

endmodule
